// File: rtl/key_debounce_bit.sv
// One key bit: two-flop synchroniser, stability counter, clean level and
// single-cycle press/release pulses. The input is already normalised (1 = pressed).
module key_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_stable,
    output logic o_press,
    output logic o_release
);

    // A count of DEBOUNCE_CYCLES-1 always fits in $clog2(DEBOUNCE_CYCLES) bits.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_press;
    logic          r_release;

    logic          w_diff;
    logic          w_term;

    assign w_diff = r_sync2 ^ r_stable;
    assign w_term = (r_cnt == TERM);

    // Bring the asynchronous key into the clock domain; resets to released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive differing samples; any agreement restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_stable  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (!w_term) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt     <= '0;
                r_stable  <= r_sync2;
                r_press   <= r_sync2;
                r_release <= ~r_sync2;
            end
        end
    end

    assign o_stable  = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Debounces W_KEY raw push-buttons into active-high clean levels with
// press/release pulses. Polarity is normalised here; each bit is independent.
module key_debounce #(
    parameter int W_KEY           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_KEY-1:0] key,
    output logic [W_KEY-1:0] key_stable,
    output logic [W_KEY-1:0] key_press,
    output logic [W_KEY-1:0] key_release
);

    // Reject nonsensical parameterisations at elaboration.
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_cycles
        $fatal(1, "key_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (W_KEY < 1) begin : g_chk_width
        $fatal(1, "key_debounce: W_KEY must be >= 1");
    end

    logic [W_KEY-1:0] w_key_n;

    // Normalise so that 1 always means pressed.
    assign w_key_n = key ^ {W_KEY{KEY_ACTIVE_LOW}};

    for (genvar g = 0; g < W_KEY; g++) begin : g_bit
        key_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .i_key    (w_key_n[g]),
            .o_stable (key_stable[g]),
            .o_press  (key_press[g]),
            .o_release(key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios then random key/reset activity,
// every cycle compared against a window-based reference model.
module tb_key_debounce;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] key = 4'hF;
    logic [W-1:0] key_stable, key_press, key_release;

    int checks = 0;
    int errs   = 0;
    int npress [W];
    int nrel   [W];

    key_debounce #(.W_KEY(W), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_stable (key_stable),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Reference model: sync2 is the normalised key two edges late; a bit flips
    // once its last D sync2 samples (all since its previous flip) disagree with
    // the clean level.
    logic [W-1:0] dq  [$] = '{4'h0, 4'h0};
    logic [W-1:0] s2h [$];
    int           since [W];
    logic [W-1:0] e_stable = '0, e_press = '0, e_rel = '0;

    always @(posedge clk) begin
        logic [W-1:0] kn, s2v;
        int n;
        bit ok;
        kn = ~key;
        if (rst) begin
            dq = '{4'h0, 4'h0};
            s2h.delete();
            for (int b = 0; b < W; b++) since[b] = 0;
            e_stable = '0; e_press = '0; e_rel = '0;
        end else begin
            s2v = dq.pop_front();
            dq.push_back(kn);
            s2h.push_back(s2v);
            n = s2h.size();
            e_press = '0; e_rel = '0;
            for (int b = 0; b < W; b++) begin
                if (n - since[b] >= D) begin
                    ok = 1'b1;
                    for (int k = n - D; k < n; k++)
                        if (s2h[k][b] == e_stable[b]) ok = 1'b0;
                    if (ok) begin
                        e_stable[b] = ~e_stable[b];
                        e_press[b]  = e_stable[b];
                        e_rel[b]    = ~e_stable[b];
                        since[b]    = n;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n cycles, comparing all outputs with the model between edges.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("stable",  32'(key_stable),  32'(e_stable));
            chk("press",   32'(key_press),   32'(e_press));
            chk("release", 32'(key_release), 32'(e_rel));
            chk("excl",    32'(key_press & key_release), 32'd0);
            for (int b = 0; b < W; b++) begin
                npress[b] += int'(key_press[b]);
                nrel[b]   += int'(key_release[b]);
            end
        end
    endtask

    initial begin
        int p0;
        logic [W-1:0] k;
        int hi_rate;
        for (int b = 0; b < W; b++) begin npress[b] = 0; nrel[b] = 0; end

        // Reset with all keys released, then idle.
        @(negedge clk);
        rst = 1'b1; key = 4'hF;
        cyc(3);
        rst = 1'b0;
        cyc(20);
        chk("idle_stable", 32'(key_stable), 32'h0);

        // Press key 0 and hold.
        key[0] = 1'b0;
        cyc(5);
        chk("press0_early", 32'(key_stable[0]), 32'h0);
        cyc(1);
        chk("press0_pulse", 32'(key_press), 32'h1);
        chk("press0_level", 32'(key_stable), 32'h1);
        cyc(6);

        // Short glitch on key 1.
        p0 = npress[1];
        key[1] = 1'b0; cyc(3);
        key[1] = 1'b1; cyc(10);
        chk("glitch_none", 32'(npress[1] - p0), 32'h0);
        chk("glitch_lvl", 32'(key_stable[1]), 32'h0);

        // Bouncing key 2, ending pressed.
        p0 = npress[2];
        for (int i = 0; i < 5; i++) begin key[2] = ~key[2]; cyc(2); end
        cyc(3);
        chk("bounce_early", 32'(key_stable[2]), 32'h0);
        cyc(1);
        chk("bounce_pulse", 32'(key_press[2]), 32'h1);
        cyc(6);
        chk("bounce_once", 32'(npress[2] - p0), 32'h1);

        // Release key 2.
        p0 = nrel[2];
        key[2] = 1'b1;
        cyc(5);
        chk("rel2_early", 32'(key_stable[2]), 32'h1);
        cyc(1);
        chk("rel2_pulse", 32'(key_release[2]), 32'h1);
        cyc(4);
        chk("rel2_once", 32'(nrel[2] - p0), 32'h1);

        // Release key 0, then press keys 0 and 3 together.
        key[0] = 1'b1; cyc(10);
        key[0] = 1'b0; key[3] = 1'b0;
        cyc(6);
        chk("simul_pulse", 32'(key_press), 32'h9);
        cyc(2);
        chk("simul_level", 32'(key_stable), 32'h9);

        // Reset in the middle of counting key 1.
        key = 4'hF; cyc(10);
        p0 = npress[1];
        key[1] = 1'b0; cyc(3);
        rst = 1'b1; cyc(2);
        rst = 1'b0;
        chk("rstmid_none", 32'(npress[1] - p0), 32'h0);
        cyc(5);
        chk("rstmid_early", 32'(key_press[1]), 32'h0);
        cyc(1);
        chk("rstmid_pulse", 32'(key_press[1]), 32'h1);
        cyc(5);
        chk("rstmid_once", 32'(npress[1] - p0), 32'h1);

        // Random activity: alternating bouncy and calm phases, rare resets.
        hi_rate = 1;
        for (int c = 0; c < 1200; c++) begin
            if (c % 40 == 0) hi_rate = ~hi_rate & 1;
            rst = ($urandom_range(0, 199) == 0);
            k = key;
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, hi_rate ? 2 : 19) == 0) k[b] = ~k[b];
            key = k;
            cyc(1);
        end
        rst = 1'b0;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
